mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (1..15).
REQ-002 Parameter: TIMEOUT, 15, max cycles waiting for mem_ready before error completion (1..255).
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  reset is asynchronous and active-low.
REQ-005 Port: if_req  in  1  instruction-fetch request, held until if_ack.
REQ-006 Port: if_addr  in  32  fetch byte address.
REQ-007 Port: if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 Port: if_rdata  out  32  fetched word, valid while if_ack=1.
REQ-009 Port: d_req  in  1  load/store request, held until d_ack.
REQ-010 Port: d_we  in  1  1=store, 0=load.
REQ-011 Port: d_addr  in  32  data byte address.
REQ-012 Port: d_wdata  in  32  store data.
REQ-013 Port: d_mode  in  3  funct3 width/sign code, passed through.
REQ-014 Port: d_ack  out  1  one-cycle data completion pulse.
REQ-015 Port: d_rdata  out  32  load result, valid while d_ack=1.
REQ-016 Port: mem_en  out  1  one-cycle access-start strobe to shared memory.
REQ-017 Port: mem_we / mem_addr / mem_wdata / mem_mode  out  1/32/32/3  access attributes.
REQ-018 Port: mem_ready  in  1  memory completion; mem_rdata valid same cycle.
REQ-019 Port: mem_rdata  in  32  memory read data.
REQ-020 Port: bus_err  out  1  pulses with ack when access timed out.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, ACK; single outstanding access.
REQ-022 IDLE: at a rising edge with any req=1, latch grant, attributes into mem_* registers, go ISSUE; else stay.
REQ-023 Arbitration: only one req -> grant it; both -> data, unless streak==STARVE_LIMIT -> fetch.
REQ-024 streak: +1 on data grant while if_req=1 (saturate at STARVE_LIMIT); cleared on fetch grant; unchanged otherwise.
REQ-025 Fetch grant drives mem_we=0, mem_mode=3'b010, mem_wdata=0.
REQ-026 ISSUE: mem_en=1 for exactly this cycle; next edge -> WAIT, or -> ACK if mem_ready=1.
REQ-027 WAIT: mem_en=0; mem_* attributes held stable from ISSUE through ACK.
REQ-028 mem_ready sampled only in ISSUE/WAIT; ignored in IDLE/ACK.
REQ-029 On mem_ready=1: register mem_rdata into granted port's rdata (loads/fetches only; stores leave d_rdata unchanged), -> ACK.
REQ-030 Wait counter counts edges in ISSUE/WAIT; on reaching TIMEOUT without mem_ready -> ACK with bus_err=1, rdata of granted read port =0.
REQ-031 ACK: granted ack=1 (and bus_err if timed out) for one cycle; requests not sampled; next edge -> IDLE.
REQ-032 Minimum latency: req sampled edge k, mem_ready at edge k+1 -> ack high between edges k+1 and k+2; next grant no earlier than edge k+3.
REQ-033 Request changes while not IDLE have no effect on the in-flight access.
REQ-034 if_ack and d_ack never high in the same cycle.

Reset
REQ-035 reset=0 immediately forces state IDLE; all outputs, rdata registers, streak and wait counter to 0, including mid-access.
REQ-036 After reset release, first request sampled at the first rising edge with reset=1.

Verification
REQ-037 Fetch only: if_addr=0x100, mem_ready 2 cycles after mem_en, mem_rdata=0x00000013 -> mem_en one cycle, mem_addr=0x100, if_ack one cycle, if_rdata=0x00000013.
REQ-038 Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_mode=3'b010 -> mem_we=1, mem_wdata=0xDEADBEEF, d_ack pulse, d_rdata unchanged.
REQ-039 Both reqs held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-040 mem_ready never asserted, TIMEOUT=15 -> ack with bus_err=1 exactly 15 edges after ISSUE entry, rdata=0.
REQ-041 reset=0 asserted during WAIT -> all outputs 0 without clock edge; fresh request after release completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access with starvation and timeout control
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [2:0]  i_d_mode,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [2:0]  o_mem_mode,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_bus_err
);
    localparam logic [3:0] LP_STARVE  = STARVE_LIMIT[3:0];
    localparam logic [7:0] LP_TIMEOUT = TIMEOUT[7:0];

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t      r_state;
    logic        r_gnt_d;
    logic [3:0]  r_streak;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_mem_mode;
    logic        r_if_ack;
    logic        r_d_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_bus_err;

    logic w_any_req;
    logic w_gnt_d;
    logic w_timeout;

    assign w_any_req = i_if_req | i_d_req;
    // data wins a tie unless fetch has already been passed over STARVE_LIMIT times in a row
    assign w_gnt_d   = i_d_req & ~(i_if_req & (r_streak == LP_STARVE));
    assign w_timeout = (r_wait_cnt + 8'd1) == LP_TIMEOUT;

    assign o_if_ack    = r_if_ack;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_ack     = r_d_ack;
    assign o_d_rdata   = r_d_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mode  = r_mem_mode;
    assign o_bus_err   = r_bus_err;

    // access FSM: grant, issue one strobe, wait for ready or timeout, pulse ack
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_gnt_d     <= 1'b0;
            r_streak    <= 4'd0;
            r_wait_cnt  <= 8'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_mode  <= 3'd0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ISSUE;
                        r_mem_en   <= 1'b1;
                        r_gnt_d    <= w_gnt_d;
                        r_wait_cnt <= 8'd0;
                        if (w_gnt_d) begin
                            r_mem_we    <= i_d_we;
                            r_mem_addr  <= i_d_addr;
                            r_mem_wdata <= i_d_wdata;
                            r_mem_mode  <= i_d_mode;
                            if (i_if_req && r_streak != LP_STARVE)
                                r_streak <= r_streak + 4'd1;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= i_if_addr;
                            r_mem_wdata <= 32'd0;
                            r_mem_mode  <= 3'b010;
                            r_streak    <= 4'd0;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    r_mem_en <= 1'b0;
                    if (i_mem_ready || w_timeout) begin
                        r_state   <= ACK;
                        r_bus_err <= ~i_mem_ready;
                        r_d_ack   <= r_gnt_d;
                        r_if_ack  <= ~r_gnt_d;
                        if (!r_gnt_d)
                            r_if_rdata <= i_mem_ready ? i_mem_rdata : 32'd0;
                        else if (!r_mem_we)
                            r_d_rdata <= i_mem_ready ? i_mem_rdata : 32'd0;
                    end else begin
                        r_state    <= WAIT;
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ACK: begin
                    r_state   <= IDLE;
                    r_if_ack  <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_bus_err <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_mode;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_if_req(if_req),
        .i_if_addr(if_addr),
        .o_if_ack(if_ack),
        .o_if_rdata(if_rdata),
        .i_d_req(d_req),
        .i_d_we(d_we),
        .i_d_addr(d_addr),
        .i_d_wdata(d_wdata),
        .i_d_mode(d_mode),
        .o_d_ack(d_ack),
        .o_d_rdata(d_rdata),
        .o_mem_en(mem_en),
        .o_mem_we(mem_we),
        .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_mode(mem_mode),
        .i_mem_ready(mem_ready),
        .i_mem_rdata(mem_rdata),
        .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; d_mode = 3'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        tick;
        chk("rst_en", 32'(mem_en), 0);
        chk("rst_acks", 32'({if_ack, d_ack, bus_err}), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        tick;
        // fetch with ready two cycles after the strobe
        rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h100; d_wdata = 32'h12345678;
        tick;
        chk("f_en", 32'(mem_en), 1);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_we", 32'(mem_we), 0);
        chk("f_mode", 32'(mem_mode), 2);
        chk("f_wdata", mem_wdata, 0);
        tick;
        chk("f_en_wait", 32'(mem_en), 0);
        if_addr = 32'h999;
        tick;
        chk("f_addr_hold", mem_addr, 32'h100);
        chk("f_noack", 32'(if_ack), 0);
        mem_ready = 1'b1; mem_rdata = 32'h13;
        tick;
        chk("f_ack", 32'(if_ack), 1);
        chk("f_rdata", if_rdata, 32'h13);
        chk("f_dack", 32'(d_ack), 0);
        chk("f_err", 32'(bus_err), 0);
        mem_ready = 1'b0; if_req = 1'b0;
        tick;
        chk("f_ack_pulse", 32'(if_ack), 0);
        // load at minimum latency, then a store queued right behind it
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h11111111; d_mode = 3'b100;
        tick;
        chk("l_en", 32'(mem_en), 1);
        chk("l_we", 32'(mem_we), 0);
        chk("l_addr", mem_addr, 32'h80);
        chk("l_mode", 32'(mem_mode), 4);
        chk("l_wdata", mem_wdata, 32'h11111111);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick;
        chk("l_ack", 32'(d_ack), 1);
        chk("l_rdata", d_rdata, 32'hCAFEF00D);
        chk("l_iack", 32'(if_ack), 0);
        mem_ready = 1'b0; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_mode = 3'b010;
        tick;
        chk("lat_idle_en", 32'(mem_en), 0);
        chk("lat_idle_ack", 32'(d_ack), 0);
        tick;
        chk("s_en", 32'(mem_en), 1);
        chk("s_we", 32'(mem_we), 1);
        chk("s_addr", mem_addr, 32'h40);
        chk("s_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_mode", 32'(mem_mode), 2);
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        tick;
        chk("s_ack", 32'(d_ack), 1);
        chk("s_rdata_kept", d_rdata, 32'hCAFEF00D);
        mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick;
        // ready while idle must not produce an ack
        mem_ready = 1'b1;
        tick;
        chk("idle_rdy_ack", 32'({if_ack, d_ack}), 0);
        chk("idle_rdy_en", 32'(mem_en), 0);
        mem_ready = 1'b0;
        tick;
        // both requesters held: data four times, then fetch
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        d_mode = 3'b001; mem_rdata = 32'hA5A5A5A5;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("arb%0d_addr", i), mem_addr, exp_d[i] ? 32'h300 : 32'h200);
            mem_ready = 1'b1;
            tick;
            chk($sformatf("arb%0d_dack", i), 32'(d_ack), 32'(exp_d[i]));
            chk($sformatf("arb%0d_iack", i), 32'(if_ack), 32'(!exp_d[i]));
            mem_ready = 1'b0;
            tick;
        end
        if_req = 1'b0; d_req = 1'b0;
        // timeout on a load
        d_req = 1'b1; d_addr = 32'h44;
        tick;
        chk("to_en", 32'(mem_en), 1);
        for (int i = 1; i < 15; i++) begin
            tick;
            chk($sformatf("to_wait%0d", i), 32'({d_ack, bus_err}), 0);
        end
        tick;
        chk("to_ack", 32'(d_ack), 1);
        chk("to_err", 32'(bus_err), 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_addr_hold", mem_addr, 32'h44);
        d_req = 1'b0;
        tick;
        chk("to_err_pulse", 32'({d_ack, bus_err}), 0);
        // reset in the middle of a waiting fetch
        if_req = 1'b1; if_addr = 32'h500;
        tick;
        tick;
        chk("rw_wait_en", 32'(mem_en), 0);
        chk("rw_wait_addr", mem_addr, 32'h500);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_addr", mem_addr, 0);
        chk("rw_if_rdata", if_rdata, 0);
        chk("rw_mode", 32'(mem_mode), 0);
        chk("rw_flags", 32'({mem_en, if_ack, d_ack, bus_err}), 0);
        if_addr = 32'h504;
        tick;
        rst_n = 1'b1;
        tick;
        chk("rr_en", 32'(mem_en), 1);
        chk("rr_addr", mem_addr, 32'h504);
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick;
        chk("rr_ack", 32'(if_ack), 1);
        chk("rr_rdata", if_rdata, 32'h77);
        mem_ready = 1'b0; if_req = 1'b0;
        tick;
        chk("rr_ack_done", 32'(if_ack), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
